// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider, signed or unsigned, one quotient bit per
//   clock. A start accepted at edge E0 takes WIDTH RUN edges, then one SIGN
//   edge that fixes up the signs and loads the result registers. The done
//   pulse is visible for the single cycle after that SIGN edge. A zero divisor
//   skips RUN and is resolved at E1.
//
// Ports
//   clock      : single clock, rising edge
//   clear      : asynchronous active-high reset
//   start      : begin a division (accepted in IDLE, or in DONE for back-to-back)
//   signed_op  : 1 = signed division, 0 = unsigned; sampled with start
//   dividend   : dividend operand, sampled with start
//   divisor    : divisor operand, sampled with start
//   quotient   : registered quotient (LO)
//   remainder  : registered remainder (HI)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse, quotient/remainder valid
//   div_zero   : high with done when the divisor was zero; held until next start
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] partRem_q, partRem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] divMag_q, divMag_d;
  logic [CW-1:0]    stepCnt_q, stepCnt_d;
  logic             negQuo_q, negQuo_d;
  logic             negRem_q, negRem_d;
  logic             zeroDiv_q, zeroDiv_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;
  logic             divZero_q, divZero_d;

  logic             dvdNeg, dsrNeg, divisorZero;
  logic [WIDTH-1:0] dvdMag, dsrMag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // Operand magnitudes are taken only for signed division.
  assign dvdNeg      = signed_op & dividend[WIDTH-1];
  assign dsrNeg      = signed_op & divisor[WIDTH-1];
  assign dvdMag      = dvdNeg ? -dividend : dividend;
  assign dsrMag      = dsrNeg ? -divisor : divisor;
  assign divisorZero = (divisor == '0);

  // One restoring step: the partial remainder gains the next dividend bit and
  // the divisor magnitude is trial-subtracted. A non-negative result is always
  // below the divisor, so bit WIDTH can only be set when the subtraction
  // underflowed; folding it into the borrow keeps every bit meaningful.
  assign shifted = {partRem_q, acc_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, divMag_q};
  assign borrow  = trial[WIDTH+1] | trial[WIDTH];

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A zero divisor goes straight to SIGN, which resolves it
  // one edge later. DONE accepts a new start so back-to-back requests are not
  // delayed by an extra IDLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = divisorZero ? SIGN : RUN;
      RUN:  if (stepCnt_q == CW'(WIDTH - 1)) state_d = SIGN;
      SIGN: state_d = DONE;
      DONE: begin
        if (start) state_d = divisorZero ? SIGN : RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    quotient  = quo_q;
    remainder = remOut_q;
    div_zero  = divZero_q;
  end

  // Datapath next-state. acc holds the dividend magnitude and shifts quotient
  // bits in from the right; for a zero divisor it keeps the raw dividend so
  // it can be returned as the remainder.
  always_comb begin
    partRem_d = partRem_q;
    acc_d     = acc_q;
    divMag_d  = divMag_q;
    stepCnt_d = stepCnt_q;
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
    zeroDiv_d = zeroDiv_q;
    quo_d     = quo_q;
    remOut_d  = remOut_q;
    divZero_d = divZero_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          partRem_d = '0;
          stepCnt_d = '0;
          divMag_d  = dsrMag;
          acc_d     = divisorZero ? dividend : dvdMag;
          negQuo_d  = dvdNeg ^ dsrNeg;
          negRem_d  = dvdNeg;
          zeroDiv_d = divisorZero;
          divZero_d = 1'b0;
        end
      end
      RUN: begin
        partRem_d = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        acc_d     = {acc_q[WIDTH-2:0], ~borrow};
        stepCnt_d = stepCnt_q + CW'(1);
      end
      SIGN: begin
        if (zeroDiv_q) begin
          quo_d     = '1;
          remOut_d  = acc_q;
          divZero_d = 1'b1;
        end else begin
          quo_d     = negQuo_q ? -acc_q : acc_q;
          remOut_d  = negRem_q ? -partRem_q : partRem_q;
          divZero_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      partRem_q <= '0;
      acc_q     <= '0;
      divMag_q  <= '0;
      stepCnt_q <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      zeroDiv_q <= 1'b0;
      quo_q     <= '0;
      remOut_q  <= '0;
      divZero_q <= 1'b0;
    end else begin
      partRem_q <= partRem_d;
      acc_q     <= acc_d;
      divMag_q  <= divMag_d;
      stepCnt_q <= stepCnt_d;
      negQuo_q  <= negQuo_d;
      negRem_q  <= negRem_d;
      zeroDiv_q <= zeroDiv_d;
      quo_q     <= quo_d;
      remOut_q  <= remOut_d;
      divZero_q <= divZero_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (WIDTH=32). A behavioural model built
//   on plain SystemVerilog division predicts busy/done/results cycle by cycle;
//   a compare process checks the DUT against it on every falling edge.
//   Directed cases pin the model with hand-computed literal results, then a
//   randomized phase drives random starts, operands and occasional clears.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic             signed_op = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic [WIDTH-1:0] quotient, remainder;
  logic             busy, done, div_zero;

  int testsRun = 0;
  int testsFailed = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .signed_op(signed_op),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  // Single comparison point: every check counts and reports through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Reference division from the arithmetic rules alone.
  function automatic void refDivide(input logic [31:0] a, input logic [31:0] b,
                                    input logic s, output logic [31:0] q,
                                    output logic [31:0] r, output logic dz);
    int sa, sb;
    dz = 1'b0;
    if (b == 32'h0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
  endfunction

  // Behavioural model: an accepted start predicts a result that appears a
  // fixed number of edges later (WIDTH+1, or 1 for a zero divisor) and stays
  // on the outputs until replaced.
  logic        mBusy = 1'b0, mDone = 1'b0, mDz = 1'b0, mAccept;
  logic [31:0] mQ = '0, mR = '0, pendQ = '0, pendR = '0;
  logic        pendDz = 1'b0;
  int          mLeft = 0;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      mBusy = 1'b0; mDone = 1'b0; mDz = 1'b0;
      mQ = '0; mR = '0; mLeft = 0;
    end else begin
      mAccept = start && (!mBusy || mDone);
      if (mAccept) begin
        refDivide(dividend, divisor, signed_op, pendQ, pendR, pendDz);
        mLeft = (divisor == 32'h0) ? 1 : WIDTH + 1;
        mBusy = 1'b1;
        mDone = 1'b0;
        mDz   = 1'b0;
      end else if (mDone) begin
        mDone = 1'b0;
        mBusy = 1'b0;
      end else if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          mDone = 1'b1;
          mQ    = pendQ;
          mR    = pendR;
          mDz   = pendDz;
        end
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clock) begin
    if (!clear) begin
      checkOutput("cmp.busy", {31'b0, busy}, {31'b0, mBusy});
      checkOutput("cmp.done", {31'b0, done}, {31'b0, mDone});
      checkOutput("cmp.quotient", quotient, mQ);
      checkOutput("cmp.remainder", remainder, mR);
      checkOutput("cmp.div_zero", {31'b0, div_zero}, {31'b0, mDz});
    end
  end

  // Run one division and check it against literal expectations. Operands
  // are scrambled right after acceptance to show they are not re-sampled.
  task automatic applyStimulus(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic s,
                               input logic [31:0] expQ, input logic [31:0] expR,
                               input logic expDz, input int expEdges);
    int n;
    @(negedge clock);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(posedge clock);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = ~s;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput({name, ".latency"}, n, expEdges);
    checkOutput({name, ".quotient"}, quotient, expQ);
    checkOutput({name, ".remainder"}, remainder, expR);
    checkOutput({name, ".div_zero"}, {31'b0, div_zero}, {31'b0, expDz});
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, cnt, first, second;

    // Asynchronous reset, checked with no clock edge in between.
    #1 clear = 1'b1;
    #1;
    checkOutput("reset.busy", {31'b0, busy}, 32'h0);
    checkOutput("reset.done", {31'b0, done}, 32'h0);
    checkOutput("reset.quotient", quotient, 32'h0);
    checkOutput("reset.remainder", remainder, 32'h0);
    checkOutput("reset.div_zero", {31'b0, div_zero}, 32'h0);
    repeat (2) @(negedge clock);
    clear = 1'b0;

    applyStimulus("unsigned", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    applyStimulus("signed", 32'hFFFF_FF9C, 32'd7, 1'b1,
                  32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    applyStimulus("divzero", 32'h1234, 32'h0, 1'b0,
                  32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    applyStimulus("ovf_signed", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                  32'h8000_0000, 32'h0, 1'b0, 33);
    applyStimulus("ovf_unsigned", 32'hFFFF_FFFF, 32'd1, 1'b0,
                  32'hFFFF_FFFF, 32'h0, 1'b0, 33);
    applyStimulus("signed_div_neg", 32'd100, 32'hFFFF_FFF9, 1'b1,
                  32'hFFFF_FFF2, 32'd2, 1'b0, 33);

    // Abort at E10: outputs drop immediately, the aborted result never shows.
    @(negedge clock);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #2 clear = 1'b1;
    #1;
    checkOutput("abort.busy", {31'b0, busy}, 32'h0);
    checkOutput("abort.done", {31'b0, done}, 32'h0);
    checkOutput("abort.quotient", quotient, 32'h0);
    checkOutput("abort.remainder", remainder, 32'h0);
    checkOutput("abort.div_zero", {31'b0, div_zero}, 32'h0);
    #1 clear = 1'b0;

    // Restart on the first edge after clear; a re-pulse at E5 is ignored.
    // A stray done from the aborted run would shorten the latency below 33.
    @(negedge clock);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1 start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock);
    #1 start = 1'b0;
    n = 5;
    while (!done && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("repulse.latency", n, 33);
    checkOutput("repulse.quotient", quotient, 32'd3);
    checkOutput("repulse.remainder", remainder, 32'd0);

    // Back-to-back with start held high.
    @(negedge clock);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clock);
    #1;
    n = 0; cnt = 0; first = 0; second = 0;
    while (n < 70) begin
      @(posedge clock);
      #1;
      n++;
      if (done) begin
        cnt++;
        if (cnt == 1) first = n;
        else if (cnt == 2) second = n;
      end
      if (n == 67) start = 1'b0;
    end
    checkOutput("b2b.pulses", cnt, 2);
    checkOutput("b2b.first", first, 33);
    checkOutput("b2b.second", second, 67);
    checkOutput("b2b.quotient", quotient, 32'd100);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      start     = ($urandom % 3 == 0);
      signed_op = $urandom % 2;
      dividend  = pickOperand();
      divisor   = pickOperand();
      if ($urandom % 400 == 0) begin
        #2 clear = 1'b1;
        #1 clear = 1'b0;
      end
    end
    @(negedge clock);
    start = 1'b0;
    repeat (40) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
